// File: rtl/alarm_arm_controller.sv
// Home alarm sequencing FSM: arm/exit/entry/siren timing, zone latching,
// and a 4-digit multiplexed 7-segment status display.
module alarm_arm_controller #(
  parameter int TICK_DIV  = 100000,
  parameter int SEC_TICKS = 1000,
  parameter int EXIT_SEC  = 10,
  parameter int ENTRY_SEC = 5,
  parameter int SIREN_SEC = 30,
  parameter int DOOR_IDX  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm_req,
  input  logic [3:0] sensor,
  output logic       alarm,
  output logic       led_armed,
  output logic       led_pending,
  output logic       led_trig,
  output logic [3:0] zone_latched,
  output logic [3:0] an,
  output logic [6:0] seg
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4,
    S_SILENCED = 3'd5
  } state_e;

  localparam int MW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;
  localparam logic [MW-1:0] MS_LAST  = MW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SEC_LAST = SW'(SEC_TICKS - 1);
  localparam logic [3:0] DOOR_M = 4'(1 << DOOR_IDX);

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  logic          arm_s1_q, arm_s2_q;
  logic [3:0]    sen_s1_q, sen_s2_q;
  state_e        state_q, state_d;
  logic [MW-1:0] ms_cnt_q, ms_cnt_d;
  logic [MW-1:0] scan_cnt_q, scan_cnt_d;
  logic [SW-1:0] sec_cnt_q, sec_cnt_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    zone_q, zone_d;
  logic [1:0]    dig_q, dig_d;
  logic          alarm_q, alarm_d;
  logic          armed_q, armed_d;
  logic          pend_q, pend_d;
  logic          trig_q, trig_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic       ms_tick, sec_tick, expire, scan_tick;
  logic [3:0] other;
  logic [3:0] nib;

  always_comb begin
    ms_tick   = (ms_cnt_q == MS_LAST);
    sec_tick  = ms_tick && (sec_cnt_q == SEC_LAST);
    expire    = sec_tick && (cnt_q == 8'd1);
    scan_tick = (scan_cnt_q == MS_LAST);
    other     = sen_s2_q & ~DOOR_M;

    state_d   = state_q;
    zone_d    = zone_q;
    cnt_d     = cnt_q;
    ms_cnt_d  = ms_tick ? '0 : ms_cnt_q + 1'b1;
    sec_cnt_d = sec_cnt_q;
    if (ms_tick)
      sec_cnt_d = (sec_cnt_q == SEC_LAST) ? '0 : sec_cnt_q + 1'b1;
    if (sec_tick && cnt_q != 8'd0)
      cnt_d = cnt_q - 8'd1;

    // Disarm beats every sensor event and timer expiry.
    if (state_q != S_DISARMED && !arm_s2_q) begin
      state_d = S_DISARMED;
      zone_d  = 4'd0;
    end else begin
      unique case (state_q)
        S_DISARMED: begin
          if (arm_s2_q && sen_s2_q == 4'd0) state_d = S_EXIT;
        end
        S_EXIT: begin
          if (expire) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (other != 4'd0) begin
            state_d = S_ALARM;
            zone_d  = zone_q | sen_s2_q;
          end else if ((sen_s2_q & DOOR_M) != 4'd0) begin
            state_d = S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (other != 4'd0) begin
            state_d = S_ALARM;
            zone_d  = zone_q | sen_s2_q;
          end else if (expire) begin
            state_d = S_ALARM;
            zone_d  = zone_q | DOOR_M;
          end
        end
        S_ALARM: begin
          zone_d = zone_q | sen_s2_q;
          if (expire) state_d = S_SILENCED;
        end
        S_SILENCED: ;
        default: state_d = S_DISARMED;
      endcase
    end

    // Timers restart on every state entry so each delay is exact.
    if (state_d != state_q) begin
      ms_cnt_d  = '0;
      sec_cnt_d = '0;
      unique case (state_d)
        S_EXIT:  cnt_d = 8'(EXIT_SEC);
        S_ENTRY: cnt_d = 8'(ENTRY_SEC);
        S_ALARM: cnt_d = 8'(SIREN_SEC);
        default: cnt_d = 8'd0;
      endcase
    end

    alarm_d = (state_d == S_ALARM);
    armed_d = (state_d == S_ARMED) || (state_d == S_ENTRY) ||
              (state_d == S_ALARM) || (state_d == S_SILENCED);
    pend_d  = (state_d == S_EXIT) || (state_d == S_ENTRY);
    trig_d  = (state_d == S_ALARM) || (state_d == S_SILENCED);

    scan_cnt_d = scan_tick ? '0 : scan_cnt_q + 1'b1;
    dig_d      = dig_q;
    an_d       = an_q;
    seg_d      = seg_q;
    unique case (dig_q)
      2'd0:    nib = cnt_q[3:0];
      2'd1:    nib = cnt_q[7:4];
      2'd2:    nib = zone_q;
      default: nib = {1'b0, state_q};
    endcase
    if (scan_tick) begin
      dig_d = dig_q + 2'd1;
      an_d  = ~(4'b0001 << dig_q);
      seg_d = glyph(nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_s1_q   <= 1'b0;
      arm_s2_q   <= 1'b0;
      sen_s1_q   <= 4'd0;
      sen_s2_q   <= 4'd0;
      state_q    <= S_DISARMED;
      ms_cnt_q   <= '0;
      scan_cnt_q <= '0;
      sec_cnt_q  <= '0;
      cnt_q      <= 8'd0;
      zone_q     <= 4'd0;
      dig_q      <= 2'd0;
      alarm_q    <= 1'b0;
      armed_q    <= 1'b0;
      pend_q     <= 1'b0;
      trig_q     <= 1'b0;
      an_q       <= 4'b1111;
      seg_q      <= 7'h7F;
    end else begin
      arm_s1_q   <= arm_req;
      arm_s2_q   <= arm_s1_q;
      sen_s1_q   <= sensor;
      sen_s2_q   <= sen_s1_q;
      state_q    <= state_d;
      ms_cnt_q   <= ms_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      sec_cnt_q  <= sec_cnt_d;
      cnt_q      <= cnt_d;
      zone_q     <= zone_d;
      dig_q      <= dig_d;
      alarm_q    <= alarm_d;
      armed_q    <= armed_d;
      pend_q     <= pend_d;
      trig_q     <= trig_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign alarm        = alarm_q;
  assign led_armed    = armed_q;
  assign led_pending  = pend_q;
  assign led_trig     = trig_q;
  assign zone_latched = zone_q;
  assign an           = an_q;
  assign seg          = seg_q;

endmodule

// File: tb/tb_alarm_arm_controller.sv
// Directed bench for alarm_arm_controller with a fast timebase
// (8 cycles per second); edges are counted from reset release.
module tb_alarm_arm_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arm_req;
  logic [3:0] sensor;
  logic       alarm, led_armed, led_pending, led_trig;
  logic [3:0] zone_latched, an;
  logic [6:0] seg;

  int total = 0;
  int bad   = 0;

  alarm_arm_controller #(
    .TICK_DIV (2),
    .SEC_TICKS(4),
    .EXIT_SEC (3),
    .ENTRY_SEC(2),
    .SIREN_SEC(2),
    .DOOR_IDX (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm_req     (arm_req),
    .sensor      (sensor),
    .alarm       (alarm),
    .led_armed   (led_armed),
    .led_pending (led_pending),
    .led_trig    (led_trig),
    .zone_latched(zone_latched),
    .an          (an),
    .seg         (seg)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    arm_req = 1'b1;
    sensor  = 4'd0;
    #12;
    chk("rst_alarm", 8'(alarm), 8'h0);
    chk("rst_armed", 8'(led_armed), 8'h0);
    chk("rst_pend", 8'(led_pending), 8'h0);
    chk("rst_trig", 8'(led_trig), 8'h0);
    chk("rst_zone", 8'(zone_latched), 8'h0);
    chk("rst_an", 8'(an), 8'h0F);
    chk("rst_seg", 8'(seg), 8'h7F);

    // edge 0: release with arm_req already high
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);
    chk("e2_pend", 8'(led_pending), 8'h0);
    chk("e2_an", 8'(an), 8'h0E);
    tick(1);
    chk("e3_pend", 8'(led_pending), 8'h1);
    chk("e3_armed", 8'(led_armed), 8'h0);
    tick(7);
    chk("e10_an", 8'(an), 8'h0E);
    chk("e10_cnt3", 8'(seg), 8'h30);
    tick(16);
    chk("e26_pend", 8'(led_pending), 8'h1);
    chk("e26_armed", 8'(led_armed), 8'h0);
    tick(1);
    chk("e27_armed", 8'(led_armed), 8'h1);
    chk("e27_pend", 8'(led_pending), 8'h0);
    tick(5);
    chk("e32_an", 8'(an), 8'h07);
    chk("e32_st2", 8'(seg), 8'h24);
    tick(2);
    chk("e34_an", 8'(an), 8'h0E);
    chk("e34_seg", 8'(seg), 8'h40);
    tick(1);
    chk("e35_an", 8'(an), 8'h0E);
    tick(1);
    chk("e36_an", 8'(an), 8'h0D);
    tick(2);
    chk("e38_an", 8'(an), 8'h0B);
    chk("e38_zone0", 8'(seg), 8'h40);
    tick(2);
    chk("e40_an", 8'(an), 8'h07);

    // door opens in ARMED -> entry delay, then alarm, then silenced
    sensor = 4'b0001;
    tick(3);
    chk("e43_pend", 8'(led_pending), 8'h1);
    chk("e43_alarm", 8'(alarm), 8'h0);
    tick(7);
    chk("e50_an", 8'(an), 8'h0E);
    chk("e50_cnt2", 8'(seg), 8'h24);
    tick(8);
    chk("e58_alarm", 8'(alarm), 8'h0);
    tick(1);
    chk("e59_alarm", 8'(alarm), 8'h1);
    chk("e59_zone", 8'(zone_latched), 8'h1);
    chk("e59_trig", 8'(led_trig), 8'h1);
    chk("e59_pend", 8'(led_pending), 8'h0);
    tick(15);
    chk("e74_alarm", 8'(alarm), 8'h1);
    tick(1);
    chk("e75_alarm", 8'(alarm), 8'h0);
    chk("e75_trig", 8'(led_trig), 8'h1);
    chk("e75_armed", 8'(led_armed), 8'h1);
    chk("e75_zone", 8'(zone_latched), 8'h1);
    tick(5);
    chk("e80_an", 8'(an), 8'h07);
    chk("e80_st5", 8'(seg), 8'h12);

    // disarm from SILENCED
    arm_req = 1'b0;
    sensor  = 4'd0;
    tick(2);
    chk("e82_trig", 8'(led_trig), 8'h1);
    tick(1);
    chk("e83_armed", 8'(led_armed), 8'h0);
    chk("e83_trig", 8'(led_trig), 8'h0);
    chk("e83_zone", 8'(zone_latched), 8'h0);

    // arming blocked by an open zone
    sensor  = 4'b0010;
    arm_req = 1'b1;
    tick(5);
    chk("e88_blocked", 8'(led_pending), 8'h0);
    sensor = 4'd0;
    tick(2);
    chk("e90_pend", 8'(led_pending), 8'h0);
    tick(1);
    chk("e91_pend", 8'(led_pending), 8'h1);
    tick(23);
    chk("e114_armed", 8'(led_armed), 8'h0);
    tick(1);
    chk("e115_armed", 8'(led_armed), 8'h1);

    // entry, then another zone trips immediately
    sensor = 4'b0001;
    tick(3);
    chk("e118_pend", 8'(led_pending), 8'h1);
    tick(2);
    sensor = 4'b0100;
    tick(2);
    chk("e122_alarm", 8'(alarm), 8'h0);
    tick(1);
    chk("e123_alarm", 8'(alarm), 8'h1);
    chk("e123_zone", 8'(zone_latched), 8'h4);
    sensor = 4'b0110;
    tick(3);
    chk("e126_zone_or", 8'(zone_latched), 8'h6);

    // disarm and a new zone in the same cycle
    arm_req = 1'b0;
    sensor  = 4'b1000;
    tick(2);
    chk("e128_alarm", 8'(alarm), 8'h1);
    chk("e128_zone", 8'(zone_latched), 8'h6);
    tick(1);
    chk("e129_alarm", 8'(alarm), 8'h0);
    chk("e129_armed", 8'(led_armed), 8'h0);
    chk("e129_trig", 8'(led_trig), 8'h0);
    chk("e129_zone", 8'(zone_latched), 8'h0);

    // re-arm, then reset mid-EXIT
    arm_req = 1'b1;
    sensor  = 4'd0;
    tick(3);
    chk("e132_pend", 8'(led_pending), 8'h1);
    tick(4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_an", 8'(an), 8'h0F);
    chk("arst_seg", 8'(seg), 8'h7F);
    chk("arst_alarm", 8'(alarm), 8'h0);
    chk("arst_pend", 8'(led_pending), 8'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);
    chk("r2_pend", 8'(led_pending), 8'h0);
    tick(1);
    chk("r3_pend", 8'(led_pending), 8'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
